// File: rtl/dds_key_pkg.sv
// dds_key_pkg: shared types and defaults for the key event decoder.
// Holds the FSM state encoding and the default cycle counts for the
// 50 MHz system clock, plus small elaboration-time helpers.
package dds_key_pkg;

    // FSM state encoding; the values are fixed so debug taps and
    // checkers can decode the state without the package.
    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        HELD     = 2'd3
    } key_state_t;

    // Defaults for a 50 MHz clock: 1.0 s to long press, 0.2 s repeat.
    localparam int LONG_CYCLES_DEF   = 50_000_000;
    localparam int REPEAT_CYCLES_DEF = 10_000_000;
    localparam int CNT_W_DEF         = 26;

    // Larger of two cycle counts.
    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // True when a counter of width w can hold values 0 .. n-1.
    function automatic bit cnt_fits(input int w, input int n);
        return (longint'(1) << w) >= longint'(n);
    endfunction

endpackage

// File: rtl/key_event_decoder_if.sv
// key_event_decoder_if: debounced key level in, action events out.
//
// Signalling: key_in is a level, already synchronous to the clock and
// free of bounce. short_pulse, long_pulse and repeat_pulse are
// single-cycle strobes with no back-pressure: the consumer must take
// them in the cycle they are high. At most one strobe is high per cycle.
// key_held is a level that is high while a press is being timed.
interface key_event_decoder_if;
    logic key_in;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic key_held;

    // Upstream side: debounce stage drives the key, observes the events.
    modport master (
        output key_in,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  key_held
    );

    // Decoder side: consumes the key level, produces the events.
    modport slave (
        input  key_in,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output key_held
    );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: times a debounced key level and emits short-press,
// long-press and auto-repeat strobes. All outputs are registered.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while held). When
// undefined, HELD only waits for release and repeat_pulse is constant 0.
module key_event_decoder
    import dds_key_pkg::*;
#(
    parameter bit ACTIVE_LEVEL  = 1'b0,
    parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    key_event_decoder_if.slave        key_if,
    output key_state_t                state_dbg
);

    // Reject configurations the counter cannot time.
    if (LONG_CYCLES < 2) begin : g_bad_long
        $error("key_event_decoder: LONG_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("key_event_decoder: REPEAT_CYCLES must be at least 2");
    end
    if (!cnt_fits(CNT_W, max_cycles(LONG_CYCLES, REPEAT_CYCLES))) begin : g_bad_width
        $error("key_event_decoder: CNT_W too narrow for the cycle counts");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    logic             act_q;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             short_q;
    logic             long_q;
    logic             held_q;

    // Normalise the key to "pressed" = 1; reset treats the key as pressed
    // so a key held through reset is ignored until released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q <= 1'b1;
        end else begin
            act_q <= (key_if.key_in == ACTIVE_LEVEL);
        end
    end

`ifdef KEY_REPEAT_EN
    logic repeat_q;

    // Press timing FSM with counter and registered strobes (repeat build).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_REL;
            cnt      <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            case (state)
                WAIT_REL: begin
                    if (!act_q) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (act_q) begin
                        state  <= PRESSED;
                        cnt    <= '0;
                        held_q <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release is checked first so it wins over the threshold.
                    if (!act_q) begin
                        short_q <= 1'b1;
                        held_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt == LONG_LAST) begin
                        long_q <= 1'b1;
                        cnt    <= '0;
                        state  <= HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!act_q) begin
                        held_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= WAIT_REL;
                    held_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_if.repeat_pulse = repeat_q;
`else
    // Press timing FSM with counter and registered strobes (no repeat).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_REL;
            cnt     <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            short_q <= 1'b0;
            long_q  <= 1'b0;
            case (state)
                WAIT_REL: begin
                    if (!act_q) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (act_q) begin
                        state  <= PRESSED;
                        cnt    <= '0;
                        held_q <= 1'b1;
                    end
                end
                PRESSED: begin
                    // Release is checked first so it wins over the threshold.
                    if (!act_q) begin
                        short_q <= 1'b1;
                        held_q  <= 1'b0;
                        state   <= IDLE;
                    end else if (cnt == LONG_LAST) begin
                        long_q <= 1'b1;
                        cnt    <= '0;
                        state  <= HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    // Counter stays at 0; only a release leaves this state.
                    if (!act_q) begin
                        held_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= WAIT_REL;
                    held_q <= 1'b0;
                end
            endcase
        end
    end

    assign key_if.repeat_pulse = 1'b0;
`endif

    assign key_if.short_pulse = short_q;
    assign key_if.long_pulse  = long_q;
    assign key_if.key_held    = held_q;
    assign state_dbg          = state;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: randomized press/release stimulus against a
// press-duration reference model. Each press pushes its expected events
// (type and edge number) into a queue; a monitor pops and compares on
// every strobe, and checks key_held against the expected hold windows.
module tb_key_event_decoder;
    import dds_key_pkg::*;

    localparam int L    = 8;
    localparam int R    = 4;
    localparam int EW   = 34;    // {type[1:0], edge[31:0]}
    localparam int HMAX = 8192;
`ifdef KEY_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif
    localparam logic [1:0] EV_SHORT  = 2'd1;
    localparam logic [1:0] EV_LONG   = 2'd2;
    localparam logic [1:0] EV_REPEAT = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    key_event_decoder_if kif ();
    key_state_t          state_dbg;

    key_event_decoder #(
        .ACTIVE_LEVEL  (1'b0),
        .LONG_CYCLES   (L),
        .REPEAT_CYCLES (R),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_if    (kif.slave),
        .state_dbg (state_dbg)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    bit            exp_held[HMAX];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h required %0h", name, edge_cnt, act, req);
        end
    endtask

    function automatic logic [EW-1:0] ev(input logic [1:0] t, input int e);
        return {t, 32'(e)};
    endfunction

    // ---------------- driver tasks ----------------
    // Hold the key active for d sampled edges, then release for gap edges.
    // Reference: act_q is high for d cycles starting after edge k. A long
    // press needs d > L and fires at edge k+1+L; repeats follow every R
    // edges while act_q is still high (edge <= k+d). Otherwise the release
    // gives a short press at edge k+d+1. key_held is high after edges k+1..k+d.
    task automatic press(input int d, input int gap);
        int k;
        k = edge_cnt + 1;
        kif.key_in = 1'b0;
        for (int e = k + 1; e <= k + d; e++) if (e < HMAX) exp_held[e] = 1'b1;
        if (d >= L + 1) begin
            exp_q.push_back(ev(EV_LONG, k + 1 + L));
            if (REP_EN) begin
                for (int e = k + 1 + L + R; e <= k + d; e += R) exp_q.push_back(ev(EV_REPEAT, e));
            end
        end else begin
            exp_q.push_back(ev(EV_SHORT, k + d + 1));
        end
        repeat (d) @(negedge clk);
        kif.key_in = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_short"},  64'(kif.short_pulse),  64'(0));
        check({tag, "_long"},   64'(kif.long_pulse),   64'(0));
        check({tag, "_repeat"}, 64'(kif.repeat_pulse), 64'(0));
        check({tag, "_held"},   64'(kif.key_held),     64'(0));
        check({tag, "_state"},  64'(state_dbg),        64'(WAIT_REL));
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        int            n;
        logic [1:0]    typ;
        logic [EW-1:0] want;
        while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < edge_cnt) begin
            want = exp_q.pop_front();
            check("missed_event", 64'(0), 64'(want));
        end
        n = int'(kif.short_pulse) + int'(kif.long_pulse) + int'(kif.repeat_pulse);
        if (n > 1) check("one_pulse_per_cycle", 64'(n), 64'(1));
        if (n >= 1) begin
            typ = kif.short_pulse ? EV_SHORT : (kif.long_pulse ? EV_LONG : EV_REPEAT);
            if (exp_q.size() == 0) begin
                check("unexpected_event", 64'(ev(typ, edge_cnt)), 64'(0));
            end else begin
                want = exp_q.pop_front();
                check("event", 64'(ev(typ, edge_cnt)), 64'(want));
            end
        end
        if (edge_cnt < HMAX) check("key_held", 64'(kif.key_held), 64'(exp_held[edge_cnt]));
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        kif.key_in = 1'b0;              // key held through reset
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Held through reset release: must stay silent.
        repeat (20) @(negedge clk);
        kif.key_in = 1'b1;
        repeat (3) @(negedge clk);
        check("state_after_release", 64'(state_dbg), 64'(IDLE));

        press(3, 4);                    // first short press after power-up
        press(3, 5);                    // short press
        press(1, 5);                    // minimum short press
        press(30, 5);                   // long press with repeats
        press(L, 5);                    // release on the threshold cycle
        press(L + 1, 5);                // just long enough for a long press

        // Asynchronous reset during HELD.
        k = edge_cnt + 1;
        kif.key_in = 1'b0;
        exp_q.push_back(ev(EV_LONG, k + 1 + L));
        for (int e = k + 1; e <= k + L + 3; e++) exp_held[e] = 1'b1;
        repeat (L + 4) @(negedge clk);  // now after edge k+L+3, in HELD
        check("held_before_reset", 64'(kif.key_held), 64'(1));
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);     // still held: no events
        kif.key_in = 1'b1;
        repeat (3) @(negedge clk);
        press(3, 5);

        // Randomized presses across short, threshold and long durations.
        for (int i = 0; i < 30; i++) begin
            press($urandom_range(1, L + 5 * R), $urandom_range(1, 4));
        end

        repeat (20) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
